// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared constants and stage payload type for the pipelined ripple adder.
// The signed-overflow helper exists only with PIPELINED_RIPPLE_ADDER_OVF_EN.
package pipelined_ripple_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  // Carry into the MSB is recovered from the MSB operand and sum bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic c_out);
    return a_msb ^ b_msb ^ s_msb ^ c_out;
  endfunction
`endif

endpackage

// File: rtl/pipelined_ripple_adder_if.sv
// Valid/ready operand and result bus of the pipelined ripple adder.
// Ovf is present only when PIPELINED_RIPPLE_ADDER_OVF_EN is defined.
interface pipelined_ripple_adder_if
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  logic             Ovf;
`endif

  modport master (
    output in_valid, A, B, Cin, in_sub, out_ready,
    input  in_ready, out_valid, Sum, Cout
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    , Ovf
`endif
  );

  modport slave (
    input  in_valid, A, B, Cin, in_sub, out_ready,
    output in_ready, out_valid, Sum, Cout
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    , Ovf
`endif
  );
endinterface

// File: rtl/adder_stage.sv
// Combinational CW-bit ripple-carry chunk adder used by each pipeline stage.
module adder_stage #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);
  logic [CW:0] c_s;

  // Bit-serial carry chain through the chunk.
  always_comb begin
    c_s    = '0;
    sum    = '0;
    c_s[0] = cin;
    for (int i = 0; i < CW; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
    cout = c_s[CW];
  end
endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor, STAGES chunks, one global stall.
// Optional signed-overflow output Ovf under PIPELINED_RIPPLE_ADDER_OVF_EN.
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic clk,
  input logic rst_n,
  pipelined_ripple_adder_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_ripple_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  logic             advance_s;
  logic             xfer_s;
  logic             cin_eff_s;
  logic [WIDTH-1:0] b_eff_s;

  // All stages shift together whenever the output slot is free or being drained.
  always_comb begin
    advance_s    = !bus.out_valid || bus.out_ready;
    xfer_s       = bus.in_valid && advance_s;
    bus.in_ready = advance_s;
  end

  // Subtract is A + ~B + 1; Cin is ignored in that mode.
  always_comb begin
    if (bus.in_sub) begin
      b_eff_s   = ~bus.B;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = bus.B;
      cin_eff_s = bus.Cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = CW * k;

    logic [WIDTH-LO-1:0]   a_src_s;
    logic [WIDTH-LO-1:0]   b_src_s;
    logic                  cin_s;
    logic                  vin_s;
    logic                  cout_s;
    logic [CW-1:0]         sum_chunk_s;
    logic [CW*(k+1)-1:0]   sum_next_s;
    logic [CW*(k+1)-1:0]   sum_r;
    stage_ctl_t            ctl_r;

    // Stage k sees only the chunks not yet added plus the sum chunks already done.
    if (k == 0) begin : g_src
      always_comb begin
        a_src_s    = bus.A;
        b_src_s    = b_eff_s;
        cin_s      = cin_eff_s;
        vin_s      = xfer_s;
        sum_next_s = sum_chunk_s;
      end
    end else begin : g_src
      always_comb begin
        a_src_s    = g_stage[k-1].g_opnd.a_r;
        b_src_s    = g_stage[k-1].g_opnd.b_r;
        cin_s      = g_stage[k-1].ctl_r.carry;
        vin_s      = g_stage[k-1].ctl_r.valid;
        sum_next_s = {sum_chunk_s, g_stage[k-1].sum_r};
      end
    end

    adder_stage #(.CW(CW)) u_add (
      .a    (a_src_s[CW-1:0]),
      .b    (b_src_s[CW-1:0]),
      .cin  (cin_s),
      .sum  (sum_chunk_s),
      .cout (cout_s)
    );

    if (k < STAGES - 1) begin : g_opnd
      logic [WIDTH-LO-CW-1:0] a_r;
      logic [WIDTH-LO-CW-1:0] b_r;

      // Unconsumed operand chunks travel with their transaction.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance_s) begin
          a_r <= a_src_s[WIDTH-LO-1:CW];
          b_r <= b_src_s[WIDTH-LO-1:CW];
        end
      end
    end

    // Stage valid, inter-stage carry and accumulated sum chunks.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_r <= '0;
        sum_r <= '0;
      end else if (advance_s) begin
        ctl_r.valid <= vin_s;
        ctl_r.carry <= cout_s;
        sum_r       <= sum_next_s;
      end
    end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_r;

      // Overflow is captured in the MSB stage so it stays aligned with Sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (advance_s) begin
          ovf_r <= signed_ovf(a_src_s[CW-1], b_src_s[CW-1], sum_chunk_s[CW-1], cout_s);
        end
      end
    end
`endif
  end

  // Results come straight from the last stage registers.
  always_comb begin
    bus.out_valid = g_stage[STAGES-1].ctl_r.valid;
    bus.Sum       = g_stage[STAGES-1].sum_r;
    bus.Cout      = g_stage[STAGES-1].ctl_r.carry;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    bus.Ovf       = g_stage[STAGES-1].g_ovf.ovf_r;
`endif
  end
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed, table-driven bench for pipelined_ripple_adder (WIDTH=16, STAGES=4).
// Ovf is also checked when PIPELINED_RIPPLE_ADDER_OVF_EN is defined.
module tb_pipelined_ripple_adder;
  import pipelined_ripple_adder_pkg::*;

  localparam int W = 16;
  localparam int S = 4;
  localparam int NV = 10;

  typedef struct {
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipelined_ripple_adder_if #(.WIDTH(W)) bus ();

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t vecs [NV];
  sb_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_pop    = 0;
  logic lat_chk  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check visible result against scoreboard head, drive, then book handshakes.
  task automatic tick(input logic iv, input vec_t v, input logic ordy, output logic acc);
    sb_t h;
    sb_t e;
    @(negedge clk);
    cyc++;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        h = exp_q[0];
        check("sum", 32'(bus.Sum), 32'(h.v.sum));
        check("cout", 32'(bus.Cout), 32'(h.v.cout));
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
        check("ovf", 32'(bus.Ovf), 32'(h.v.ovf));
`endif
      end
    end
    bus.in_valid  = iv;
    bus.A         = v.a;
    bus.B         = v.b;
    bus.Cin       = v.cin;
    bus.in_sub    = v.sub;
    bus.out_ready = ordy;
    #1;
    acc = iv && bus.in_ready;
    if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
      h = exp_q.pop_front();
      n_pop++;
      if (lat_chk) check("latency", 32'(cyc - h.acc_cyc), 32'd4);
    end
    if (acc) begin
      e.v = v;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  // Offer vecs[first +: count] back to back, optionally withholding out_ready.
  task automatic run_stream(input int first, input int count, input int stall_at, input int stall_len);
    int   i;
    int   t;
    int   pops0;
    logic acc;
    logic ordy;
    logic feeding;
    i       = first;
    t       = 0;
    pops0   = n_pop;
    lat_chk = (stall_len == 0);
    while ((i < first + count || exp_q.size() > 0) && t < 60) begin
      ordy    = !(t >= stall_at && t < stall_at + stall_len);
      feeding = (i < first + count);
      if (feeding) tick(1'b1, vecs[i], ordy, acc);
      else         tick(1'b0, vecs[0], ordy, acc);
      if (!ordy) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      else if (stall_len == 0 && feeding) check("accept", 32'(acc), 32'd1);
      if (acc) i++;
      t++;
    end
    check("stream_done", 32'(t < 60), 32'd1);
    check("result_count", 32'(n_pop - pops0), 32'(count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   seen;

    vecs[0] = '{sub:1'b0, cin:1'b0, a:16'hFFFF, b:16'h0001, sum:16'h0000, cout:1'b1, ovf:1'b0};
    vecs[1] = '{sub:1'b1, cin:1'b0, a:16'h0005, b:16'h0007, sum:16'hFFFE, cout:1'b0, ovf:1'b0};
    vecs[2] = '{sub:1'b1, cin:1'b0, a:16'h0007, b:16'h0005, sum:16'h0002, cout:1'b1, ovf:1'b0};
    vecs[3] = '{sub:1'b0, cin:1'b1, a:16'h1234, b:16'h4321, sum:16'h5556, cout:1'b0, ovf:1'b0};
    vecs[4] = '{sub:1'b0, cin:1'b0, a:16'h8000, b:16'h8000, sum:16'h0000, cout:1'b1, ovf:1'b1};
    vecs[5] = '{sub:1'b0, cin:1'b0, a:16'h0FFF, b:16'h0001, sum:16'h1000, cout:1'b0, ovf:1'b0};
    vecs[6] = '{sub:1'b0, cin:1'b1, a:16'hFFFF, b:16'hFFFF, sum:16'hFFFF, cout:1'b1, ovf:1'b0};
    vecs[7] = '{sub:1'b1, cin:1'b0, a:16'h0000, b:16'h0000, sum:16'h0000, cout:1'b1, ovf:1'b0};
    vecs[8] = '{sub:1'b0, cin:1'b0, a:16'h7FFF, b:16'h0001, sum:16'h8000, cout:1'b0, ovf:1'b1};
    vecs[9] = '{sub:1'b1, cin:1'b1, a:16'hABCD, b:16'h1234, sum:16'h9999, cout:1'b1, ovf:1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = 16'h0000;
    bus.B         = 16'h0000;
    bus.Cin       = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.Sum), 32'd0);
    check("rst_cout", 32'(bus.Cout), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Each vector alone: exact 4-cycle latency and result.
    for (int k = 0; k < NV; k++) begin
      run_stream(k, 1, 0, 0);
    end

    // All vectors back to back: one result per cycle, in order.
    run_stream(0, NV, 0, 0);

    // Full pipe with out_ready low for 3 cycles.
    run_stream(2, 8, 4, 3);

    // Reset with one held result and three transactions in flight.
    lat_chk = 1'b1;
    for (int k = 3; k < 7; k++) begin
      tick(1'b1, vecs[k], 1'b1, acc);
    end
    tick(1'b0, vecs[0], 1'b0, acc);
    check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_sum", 32'(bus.Sum), 32'd0);
    check("async_rst_cout", 32'(bus.Cout), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    check("async_rst_ovf", 32'(bus.Ovf), 32'd0);
`endif
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, vecs[0], 1'b1, acc);
      if (bus.out_valid) seen++;
    end
    check("post_reset_quiet", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
